// File: rtl/mlsu_pkg.sv
// Shared types and default constants for the matrix load/store unit control path.
package mlsu_pkg;

  // Default dispatcher geometry: unit 0 = load, unit 1 = store.
  localparam int unsigned MlsuDispNrUnits   = 2;
  localparam int unsigned MlsuDispDepth     = 4;
  localparam int unsigned MlsuDispDataWidth = 128;
  localparam int unsigned MlsuDispMaxIssued = 8;

  // Index of a downstream execution unit.
  typedef logic [$clog2(MlsuDispNrUnits)-1:0] mlsu_unit_id_t;

  // Per-unit queue occupancy (0..Depth inclusive).
  typedef logic [$clog2(MlsuDispDepth+1)-1:0] mlsu_occ_t;

endpackage

// File: rtl/mlsu_dispatch_fifo.sv
// Single-clock descriptor queue for one execution unit. No pass-through:
// a push into a full queue is dropped even if the same cycle pops.
module mlsu_dispatch_fifo #(
  parameter int unsigned Depth     = 4,
  parameter int unsigned DataWidth = 128,
  localparam int unsigned PtrW     = $clog2(Depth),
  localparam int unsigned CntW     = $clog2(Depth + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 push_i,
  input  logic [DataWidth-1:0] data_i,
  input  logic                 pop_i,
  input  logic                 flush_i,
  output logic [DataWidth-1:0] data_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic [CntW-1:0]      count_o
);

  logic [DataWidth-1:0] r_mem [Depth];
  logic [PtrW-1:0]      r_wptr;
  logic [PtrW-1:0]      r_rptr;
  logic [CntW-1:0]      r_count;

  logic w_push;
  logic w_pop;

  assign full_o  = (r_count == CntW'(Depth));
  assign empty_o = (r_count == '0);
  assign w_push  = push_i & ~full_o & ~flush_i;
  assign w_pop   = pop_i & ~empty_o;
  assign data_o  = r_mem[r_rptr];
  assign count_o = r_count;

  // Pointer and occupancy bookkeeping; flush discards every stored entry.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PtrW'(1);
      if (w_pop)  r_rptr <= r_rptr + PtrW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage; write only, so it maps onto plain RAM/flops.
  always_ff @(posedge clk_i) begin
    // NOTE: the storage array has no reset; validity is tracked solely by
    // r_count, so stale words are never observed as valid data.
    if (w_push) r_mem[r_wptr] <= data_i;
  end

endmodule

// File: rtl/mlsu_ctrl_dispatch.sv
// Control-descriptor dispatcher: routes descriptors from the matrix control
// machine into per-unit queues, limits outstanding descriptors per unit,
// enforces barrier ordering and supports flushing of queued work.
module mlsu_ctrl_dispatch
  import mlsu_pkg::*;
#(
  parameter int unsigned NrUnits   = MlsuDispNrUnits,
  parameter int unsigned Depth     = MlsuDispDepth,
  parameter int unsigned DataWidth = MlsuDispDataWidth,
  parameter int unsigned MaxIssued = MlsuDispMaxIssued,
  localparam int unsigned UnitW    = $clog2(NrUnits),
  localparam int unsigned OccW     = $clog2(Depth + 1)
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              in_valid_i,
  output logic                              in_ready_o,
  input  logic [DataWidth-1:0]              in_data_i,
  input  logic [UnitW-1:0]                  in_unit_i,
  input  logic                              in_barrier_i,
  output logic                              update_o,
  output logic [NrUnits-1:0]                out_valid_o,
  input  logic [NrUnits-1:0]                out_ready_i,
  output logic [NrUnits-1:0][DataWidth-1:0] out_data_o,
  input  logic [NrUnits-1:0]                done_i,
  input  logic                              flush_i,
  output logic [NrUnits-1:0][OccW-1:0]      occ_o,
  output logic                              idle_o,
  output logic                              err_o
);

  localparam int unsigned IssW = $clog2(MaxIssued + 1);

  logic [IssW-1:0]    r_issued [NrUnits];
  logic               r_err;

  logic [NrUnits-1:0] w_full;
  logic [NrUnits-1:0] w_empty;
  logic [NrUnits-1:0] w_push;
  logic [NrUnits-1:0] w_pop;
  logic [NrUnits-1:0] w_unit_idle;
  logic [NrUnits-1:0] w_err_evt;
  logic               w_target_ok;
  logic               w_target_full;
  logic               w_others_idle;

  // Decode the target unit: does it exist, is it full, and are all other units idle.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the loop can leave it unassigned and infer a latch.
    w_target_ok   = 1'b0;
    w_target_full = 1'b0;
    w_others_idle = 1'b1;
    for (int u = 0; u < NrUnits; u++) begin
      if (in_unit_i == UnitW'(u)) begin
        w_target_ok   = 1'b1;
        w_target_full = w_full[u];
      end else if (!w_unit_idle[u]) begin
        w_others_idle = 1'b0;
      end
    end
  end

  // Ready never looks at in_valid_i; a barrier only waits on the other units.
  assign in_ready_o = ~flush_i & w_target_ok & ~w_target_full &
                      (~in_barrier_i | w_others_idle);
  assign update_o   = in_valid_i & in_ready_o;
  assign idle_o     = &w_unit_idle;
  assign err_o      = r_err;

  for (genvar g = 0; g < NrUnits; g++) begin : g_unit
    assign w_push[g]      = update_o & (in_unit_i == UnitW'(g));
    assign out_valid_o[g] = ~w_empty[g] & (r_issued[g] < IssW'(MaxIssued));
    assign w_pop[g]       = out_valid_o[g] & out_ready_i[g];
    assign w_unit_idle[g] = w_empty[g] & (r_issued[g] == '0);
    assign w_err_evt[g]   = done_i[g] & ~w_pop[g] & (r_issued[g] == '0);

    mlsu_dispatch_fifo #(
      .Depth     (Depth),
      .DataWidth (DataWidth)
    ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (w_push[g]),
      .data_i  (in_data_i),
      .pop_i   (w_pop[g]),
      .flush_i (flush_i),
      .data_o  (out_data_o[g]),
      .full_o  (w_full[g]),
      .empty_o (w_empty[g]),
      .count_o (occ_o[g])
    );
  end

  // Track descriptors handed to each unit but not yet reported done.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int u = 0; u < NrUnits; u++) r_issued[u] <= '0;
    end else begin
      for (int u = 0; u < NrUnits; u++) begin
        case ({w_pop[u], done_i[u]})
          2'b10:   r_issued[u] <= r_issued[u] + IssW'(1);
          2'b01:   if (r_issued[u] != '0) r_issued[u] <= r_issued[u] - IssW'(1);
          default: r_issued[u] <= r_issued[u];
        endcase
      end
    end
  end

  // Sticky flag for a completion pulse that matches no outstanding descriptor.
  always_ff @(posedge clk_i) begin
    if (rst_i)           r_err <= 1'b0;
    else if (|w_err_evt) r_err <= 1'b1;
  end

endmodule
